// File: rtl/bram_fifo_pkg.sv
// Shared defaults for the BRAM-backed FIFO: geometry and almost-full margin.
package bram_fifo_pkg;

  localparam int DEFAULT_DATA_SZ = 16;
  localparam int DEFAULT_ADDR_SZ = 8;
  localparam int AFULL_MARGIN    = 4;

endpackage

// File: rtl/bram.sv
// Simple dual-port block RAM: one write port, one registered read port.
module bram #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [ADDR_SZ-1:0] i_waddr,
  input  logic [DATA_SZ-1:0] i_wdata,
  input  logic               i_rd_en,
  input  logic [ADDR_SZ-1:0] i_raddr,
  output logic [DATA_SZ-1:0] o_rdata
);

  logic [DATA_SZ-1:0] mem [2**ADDR_SZ];

  // NOTE: no reset on the array or the read register, otherwise the tools
  // cannot map this onto a block RAM primitive.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_waddr] <= i_wdata;
    if (i_rd_en) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO around one bram, hiding its 1-cycle read latency.
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int DATA_SZ   = DEFAULT_DATA_SZ,
  parameter int ADDR_SZ   = DEFAULT_ADDR_SZ,
  parameter int AFULL_LVL = (1 << ADDR_SZ) - AFULL_MARGIN
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  input  logic [DATA_SZ-1:0] i_wr_data,
  output logic               o_rd_valid,
  input  logic               i_rd_ready,
  output logic [DATA_SZ-1:0] o_rd_data,
  output logic [ADDR_SZ:0]   o_count,
  output logic               o_afull
);

  localparam int             MEM_MAX   = 1 << ADDR_SZ;
  localparam logic [ADDR_SZ:0] FULL_CNT  = MEM_MAX[ADDR_SZ:0];
  localparam logic [ADDR_SZ:0] AFULL_CNT = AFULL_LVL[ADDR_SZ:0];

  logic [ADDR_SZ:0] wr_ptr;
  logic [ADDR_SZ:0] rd_ptr;
  logic [ADDR_SZ:0] rd_ptr_next;
  logic             wr_fire;
  logic             rd_fire;

  assign o_count    = wr_ptr - rd_ptr;
  assign o_wr_ready = (o_count != FULL_CNT);
  assign o_afull    = (o_count >= AFULL_CNT);

  assign wr_fire     = i_wr_valid & o_wr_ready;
  assign rd_fire     = o_rd_valid & i_rd_ready;
  // Address the next head one cycle early so bram's registered output lands on time.
  assign rd_ptr_next = rd_ptr + {{ADDR_SZ{1'b0}}, rd_fire};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_next;
      // Pre-update wr_ptr: a word is visible only once bram has stored it.
      o_rd_valid <= (wr_ptr != rd_ptr_next);
    end
  end

  bram #(
    .DATA_SZ (DATA_SZ),
    .ADDR_SZ (ADDR_SZ)
  ) u_bram (
    .i_clk   (i_clk),
    .i_wr_en (wr_fire),
    .i_waddr (wr_ptr[ADDR_SZ-1:0]),
    .i_wdata (i_wr_data),
    .i_rd_en (1'b1),
    .i_raddr (rd_ptr_next[ADDR_SZ-1:0]),
    .o_rdata (o_rd_data)
  );

endmodule

// File: tb/tb_bram_fifo.sv
// Directed bench for bram_fifo at ADDR_SZ=4 (16 words, almost-full at 12).
module tb_bram_fifo;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          afull;

  int checks = 0;
  int errors = 0;

  bram_fifo #(.DATA_SZ(DW), .ADDR_SZ(AW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_valid (wr_valid),
    .o_wr_ready (wr_ready),
    .i_wr_data  (wr_data),
    .o_rd_valid (rd_valid),
    .i_rd_ready (rd_ready),
    .o_rd_data  (rd_data),
    .o_count    (count),
    .o_afull    (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      rd_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rd_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", afull); end
  endtask

  task automatic test_latency();
    wr_valid = 1'b1; wr_data = 16'h1234; rd_ready = 1'b0;
    @(negedge clk);  // E0 has passed
    wr_valid = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_e0 got %b want 0", rd_valid); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL lat_count_e0 got %0d want 1", count); end
    @(negedge clk);  // E1 has passed
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL lat_valid_e1 got %b want 1", rd_valid); end
    checks++; if (rd_data !== 16'h1234) begin errors++; $display("FAIL lat_data got %h want 1234", rd_data); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'h1234 || count !== 5'd1) begin
        errors++;
        $display("FAIL lat_hold cyc %0d got v=%b d=%h c=%0d want v=1 d=1234 c=1", i, rd_valid, rd_data, count);
      end
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL lat_drain got v=%b c=%0d want v=0 c=0", rd_valid, count); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (count !== 5'(i) || wr_ready !== 1'b1 || afull !== (i >= 12)) begin
        errors++;
        $display("FAIL fill idx %0d got c=%0d rdy=%b af=%b want c=%0d rdy=1 af=%b", i, count, wr_ready, afull, i, (i >= 12));
      end
      wr_valid = 1'b1; wr_data = 16'(i);
      @(negedge clk);
    end
    checks++;
    if (count !== 5'd16 || wr_ready !== 1'b0 || afull !== 1'b1) begin
      errors++; $display("FAIL full got c=%0d rdy=%b af=%b want c=16 rdy=0 af=1", count, wr_ready, afull);
    end
    wr_data = 16'h00AA;  // 17th offer must be refused
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL overflow_count got %0d want 16", count); end
    for (int i = 0; i < DEPTH; i++) begin
      rd_ready = 1'b1;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'(i) || count !== 5'(DEPTH - i)) begin
        errors++;
        $display("FAIL drain idx %0d got v=%b d=%h c=%0d want v=1 d=%h c=%0d", i, rd_valid, rd_data, count, 16'(i), DEPTH - i);
      end
      if (i == 1) begin
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL drain_wr_ready got %b want 1", wr_ready); end
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL drained got v=%b c=%0d want v=0 c=0", rd_valid, count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 16'(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      wr_valid = 1'b1; wr_data = 16'(i + 3); rd_ready = 1'b1;
      checks++;
      if (count !== 5'd3 || rd_valid !== 1'b1 || rd_data !== 16'(i)) begin
        errors++;
        $display("FAIL stream idx %0d got c=%0d v=%b d=%h want c=3 v=1 d=%h", i, count, rd_valid, rd_data, 16'(i));
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    for (int i = 100; i < 103; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'(i)) begin
        errors++; $display("FAIL stream_tail idx %0d got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 16'(i));
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL stream_end_count got %0d want 0", count); end
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    logic [DW-1:0] d;
    logic          wv, rr;
    int            bad = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      wv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      d  = 16'($urandom);
      wr_valid = wv; wr_data = d; rd_ready = rr;
      checks++;
      if (count !== 5'(q.size()) || wr_ready !== (q.size() != DEPTH) || (rd_valid && q.size() == 0)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_state cyc %0d got c=%0d rdy=%b v=%b want c=%0d", cyc, count, wr_ready, rd_valid, q.size());
      end
      if (rd_valid && rr && q.size() > 0) begin
        checks++;
        if (rd_data !== q[0]) begin
          errors++; bad++;
          if (bad < 10) $display("FAIL rand_data cyc %0d got %h want %h", cyc, rd_data, q[0]);
        end
        void'(q.pop_front());
      end
      if (wv && q.size() < DEPTH + (rd_valid && rr ? 1 : 0) && count != 5'(DEPTH)) q.push_back(d);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      if (rd_valid) begin
        checks++;
        if (rd_data !== q[0]) begin errors++; $display("FAIL rand_flush got %h want %h", rd_data, q[0]); end
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++; if (q.size() != 0 || count !== 5'd0) begin errors++; $display("FAIL rand_leftover got c=%0d model=%0d want 0", count, q.size()); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1; wr_data = 16'h0500 + 16'(i);
      @(negedge clk);
    end
    checks++; if (count !== 5'd7 || rd_valid !== 1'b1) begin errors++; $display("FAIL pre_reset got c=%0d v=%b want c=7 v=1", count, rd_valid); end
    wr_data = 16'hDEAD; rd_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL async_reset got v=%b c=%0d want v=0 c=0", rd_valid, count); end
    repeat (2) @(negedge clk);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_ignore got c=%0d want 0", count); end
    wr_valid = 1'b0; rd_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 16'hBEEF;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF || count !== 5'd1) begin
      errors++; $display("FAIL post_reset got v=%b d=%h c=%0d want v=1 d=beef c=1", rd_valid, rd_data, count);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    idle(2);
    test_fill_drain();
    idle(2);
    test_back_to_back();
    idle(2);
    test_random();
    idle(2);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
